// File: rtl/autoconfig_pkg.sv
// Shared definitions for the Zorro II autoconfig chain.
//   - Register offsets, given as A[6:1] values (byte offset / 2).
//   - er_type field layout and size codes.
//   - Engine state encoding.
//   - A small nibble-extract helper.
package autoconfig_pkg;

  // Base of the autoconfig window, A[23:16].
  localparam logic [7:0] CFG_WINDOW      = 8'hE8;

  // Read offsets.
  localparam logic [5:0] OFF_ER_TYPE_HI  = 6'h00;  // $00
  localparam logic [5:0] OFF_ER_TYPE_LO  = 6'h01;  // $02
  localparam logic [5:0] OFF_PRODUCT_HI  = 6'h02;  // $04
  localparam logic [5:0] OFF_PRODUCT_LO  = 6'h03;  // $06
  localparam logic [5:0] OFF_FLAGS_HI    = 6'h04;  // $08
  localparam logic [5:0] OFF_FLAGS_LO    = 6'h05;  // $0A
  localparam logic [5:0] OFF_MANUF_0     = 6'h08;  // $10, most significant nibble
  localparam logic [5:0] OFF_MANUF_3     = 6'h0B;  // $16
  localparam logic [5:0] OFF_SERIAL_0    = 6'h0C;  // $18, most significant nibble
  localparam logic [5:0] OFF_SERIAL_7    = 6'h13;  // $26
  localparam logic [5:0] OFF_CTRL_HI     = 6'h20;  // $40
  localparam logic [5:0] OFF_CTRL_LO     = 6'h21;  // $42

  // Write offsets.
  localparam logic [5:0] OFF_BASE_HI     = 6'h24;  // $48
  localparam logic [5:0] OFF_BASE_LO     = 6'h25;  // $4A
  localparam logic [5:0] OFF_SHUTUP      = 6'h26;  // $4C

  // er_type byte layout.
  typedef enum logic [1:0] {
    ERT_ZORRO_II = 2'b11
  } er_board_type_e;

  typedef enum logic [2:0] {
    ER_SIZE_8M   = 3'b000,
    ER_SIZE_64K  = 3'b001,
    ER_SIZE_128K = 3'b010,
    ER_SIZE_256K = 3'b011,
    ER_SIZE_512K = 3'b100,
    ER_SIZE_1M   = 3'b101,
    ER_SIZE_2M   = 3'b110,
    ER_SIZE_4M   = 3'b111
  } er_size_e;

  typedef struct packed {
    er_board_type_e board_type;  // [7:6]
    logic           link_memory; // [5] board is memory for the free pool
    logic           rom_vector;  // [4]
    logic           chained;     // [3] another board follows on this card
    er_size_e       size;        // [2:0]
  } er_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_DONE  = 2'd2
  } ac_state_e;

  // Nibble pos of a 32-bit word, pos 0 being the least significant nibble.
  function automatic logic [3:0] nibble_of(input logic [31:0] word, input logic [2:0] pos);
    return word[{pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/autoconfig_rom_nibble.sv
// Autoconfig ROM nibble mux for one board.
//   a_low   : A[6:1] of the current access
//   er_type : er_type byte of the board being configured
//   product : product byte of the board being configured
//   nibble  : value to present on D[15:12]
// Everything except er_type and the $40/$42 control registers reads inverted.
module autoconfig_rom_nibble
  import autoconfig_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h0A1C,
  parameter logic [31:0] SERIAL   = 32'h0000_0000
) (
  input  logic [5:0] a_low,
  input  logic [7:0] er_type,
  input  logic [7:0] product,
  output logic [3:0] nibble
);

  logic [2:0] rel_manuf_s;
  logic [2:0] rel_serial_s;

  // Position inside the manufacturer / serial runs; modulo-8 arithmetic is exact here.
  assign rel_manuf_s  = a_low[2:0] - OFF_MANUF_0[2:0];
  assign rel_serial_s = a_low[2:0] - OFF_SERIAL_0[2:0];

  // Offset decode, most significant nibble at the lowest address.
  always_comb begin
    nibble = 4'hF;
    case (a_low) inside
      OFF_ER_TYPE_HI:              nibble = er_type[7:4];
      OFF_ER_TYPE_LO:              nibble = er_type[3:0];
      OFF_PRODUCT_HI:              nibble = ~product[7:4];
      OFF_PRODUCT_LO:              nibble = ~product[3:0];
      OFF_FLAGS_HI, OFF_FLAGS_LO:  nibble = ~4'h0;
      [OFF_MANUF_0:OFF_MANUF_3]:   nibble = ~nibble_of({16'h0000, MANUF_ID}, 3'd3 - rel_manuf_s);
      [OFF_SERIAL_0:OFF_SERIAL_7]: nibble = ~nibble_of(SERIAL, 3'd7 - rel_serial_s);
      OFF_CTRL_HI, OFF_CTRL_LO:    nibble = 4'h0;
      default:                     nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II autoconfig engine presenting N_BOARDS logical boards in turn on one
// CFGIN_n/CFGOUT_n link.
//   C7M, RESET         : clock, synchronous active-high reset
//   CFGIN_n / CFGOUT_n : config chain in / out
//   AS_n, DS_n, RW_n   : 68000 strobes (AS_n/DS_n asynchronous) and direction
//   A_HIGH, A_LOW      : A[23:16], A[6:1]
//   D_IN / D_OUT, D_OE : D[15:12] write data, read nibble and its enables
//   BASE_ADDR, CONFIGURED_n, SHUTUP : per-board results of configuration
//   ACTIVE_IDX         : board currently answering (saturates at the last board)
module autoconfig_chain
  import autoconfig_pkg::*;
#(
  parameter int                    N_BOARDS    = 2,
  parameter logic [15:0]           MANUF_ID    = 16'h0A1C,
  parameter logic [31:0]           SERIAL      = 32'h0000_0000,
  parameter logic [8*N_BOARDS-1:0] ER_TYPE_VEC = {8'hE6, 8'hC1},
  parameter logic [8*N_BOARDS-1:0] PRODUCT_VEC = {8'h02, 8'h01}
) (
  input  logic                    C7M,
  input  logic                    RESET,
  input  logic                    CFGIN_n,
  input  logic                    AS_n,
  input  logic                    DS_n,
  input  logic                    RW_n,
  input  logic [7:0]              A_HIGH,
  input  logic [5:0]              A_LOW,
  input  logic [3:0]              D_IN,
  output logic [3:0]              D_OUT,
  output logic [3:0]              D_OE,
  output logic [8*N_BOARDS-1:0]   BASE_ADDR,
  output logic [N_BOARDS-1:0]     CONFIGURED_n,
  output logic [N_BOARDS-1:0]     SHUTUP,
  output logic                    CFGOUT_n,
  output logic [1:0]              ACTIVE_IDX
);

  localparam logic [2:0] N_END  = 3'(N_BOARDS);
  localparam logic [2:0] N_LAST = 3'(N_BOARDS) - 3'd1;

  logic                  as_meta_q, as_s_q, ds_meta_q, ds_s_q;
  ac_state_e             state_q, state_d;
  logic [3:0]            d_oe_q, d_oe_d, d_out_q, d_out_d, lo_latch_q, lo_latch_d;
  logic [2:0]            idx_q, idx_d;
  logic [8*N_BOARDS-1:0] base_q, base_d;
  logic [N_BOARDS-1:0]   cfg_n_q, cfg_n_d, shutup_q, shutup_d;
  logic                  cfgout_n_q, cfgout_n_d;
  logic [1:0]            active_idx_q, active_idx_d, sel_idx_s;
  logic                  hit_s, wr_s;
  logic [3:0]            rom_nib_s;
  logic [7:0]            er_type_arr [N_BOARDS];
  logic [7:0]            product_arr [N_BOARDS];

  for (genvar g = 0; g < N_BOARDS; g++) begin : g_board_id
    assign er_type_arr[g] = ER_TYPE_VEC[8*g +: 8];
    assign product_arr[g] = PRODUCT_VEC[8*g +: 8];
  end

  // Once every board is done idx sits at N_BOARDS; keep the ROM index in range.
  assign sel_idx_s = (idx_q < N_END) ? idx_q[1:0] : N_LAST[1:0];
  assign hit_s     = !CFGIN_n && (idx_q < N_END) && (A_HIGH == CFG_WINDOW) && !as_s_q;

  autoconfig_rom_nibble #(
    .MANUF_ID (MANUF_ID),
    .SERIAL   (SERIAL)
  ) u_rom (
    .a_low    (A_LOW),
    .er_type  (er_type_arr[sel_idx_s]),
    .product  (product_arr[sel_idx_s]),
    .nibble   (rom_nib_s)
  );

  // Bus-cycle FSM. A hit in IDLE is handled like CYCLE so the strobe-to-action
  // latency is the same whether DS_n falls with AS_n or later.
  always_comb begin
    state_d = state_q;
    d_oe_d  = d_oe_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit_s) begin
          state_d = ST_IDLE;
          d_oe_d  = 4'h0;
        end else if (!ds_s_q && !RW_n) begin
          wr_s    = 1'b1;
          state_d = ST_DONE;
          d_oe_d  = 4'h0;
        end else if (!ds_s_q) begin
          state_d = ST_CYCLE;
          d_oe_d  = 4'hF;
        end else begin
          state_d = ST_CYCLE;
          d_oe_d  = 4'h0;
        end
      end
      ST_CYCLE: begin
        if (as_s_q) begin
          state_d = ST_IDLE;
          d_oe_d  = 4'h0;
        end else if (!ds_s_q && !RW_n) begin
          wr_s    = 1'b1;
          state_d = ST_DONE;
          d_oe_d  = 4'h0;
        end else if (!ds_s_q) begin
          d_oe_d  = 4'hF;
        end else begin
          d_oe_d  = d_oe_q;
        end
      end
      ST_DONE: begin
        d_oe_d = 4'h0;
        if (as_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        d_oe_d  = 4'h0;
      end
    endcase
  end

  // Register writes, chain output and display index.
  always_comb begin
    idx_d      = idx_q;
    lo_latch_d = lo_latch_q;
    base_d     = base_q;
    cfg_n_d    = cfg_n_q;
    shutup_d   = shutup_q;
    if (wr_s) begin
      case (A_LOW)
        OFF_BASE_LO: lo_latch_d = D_IN;
        OFF_BASE_HI: begin
          for (int i = 0; i < N_BOARDS; i++) begin
            if (idx_q == 3'(i)) begin
              base_d[8*i +: 8] = {D_IN, lo_latch_q};
              cfg_n_d[i]       = 1'b0;
            end else begin
              base_d[8*i +: 8] = base_q[8*i +: 8];
            end
          end
          idx_d = idx_q + 3'd1;
        end
        OFF_SHUTUP: begin
          for (int i = 0; i < N_BOARDS; i++) begin
            if (idx_q == 3'(i)) begin
              shutup_d[i] = 1'b1;
            end else begin
              shutup_d[i] = shutup_q[i];
            end
          end
          idx_d = idx_q + 3'd1;
        end
        default: idx_d = idx_q;
      endcase
    end else begin
      idx_d = idx_q;
    end
    // Built from idx_d so the chain output moves on the same edge as the commit.
    cfgout_n_d   = (idx_d != N_END) | CFGIN_n;
    active_idx_d = (idx_d < N_END) ? idx_d[1:0] : N_LAST[1:0];
    // Address is only trusted while AS is asserted; otherwise hold the last nibble.
    d_out_d      = as_s_q ? d_out_q : rom_nib_s;
  end

  // All state: strobe synchronisers, FSM and registered outputs.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      as_meta_q    <= 1'b1;
      as_s_q       <= 1'b1;
      ds_meta_q    <= 1'b1;
      ds_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      d_oe_q       <= 4'h0;
      d_out_q      <= 4'h0;
      lo_latch_q   <= 4'h0;
      idx_q        <= 3'd0;
      base_q       <= '0;
      cfg_n_q      <= '1;
      shutup_q     <= '0;
      cfgout_n_q   <= 1'b1;
      active_idx_q <= 2'd0;
    end else begin
      as_meta_q    <= AS_n;
      as_s_q       <= as_meta_q;
      ds_meta_q    <= DS_n;
      ds_s_q       <= ds_meta_q;
      state_q      <= state_d;
      d_oe_q       <= d_oe_d;
      d_out_q      <= d_out_d;
      lo_latch_q   <= lo_latch_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      cfg_n_q      <= cfg_n_d;
      shutup_q     <= shutup_d;
      cfgout_n_q   <= cfgout_n_d;
      active_idx_q <= active_idx_d;
    end
  end

  assign D_OUT        = d_out_q;
  assign D_OE         = d_oe_q;
  assign BASE_ADDR    = base_q;
  assign CONFIGURED_n = cfg_n_q;
  assign SHUTUP       = shutup_q;
  assign CFGOUT_n     = cfgout_n_q;
  assign ACTIVE_IDX   = active_idx_q;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Bench for autoconfig_chain: a transaction-level model of the config
// registers is compared against the DUT outputs on every falling clock edge,
// with literal expectations on top for the directed scenarios.
module tb_autoconfig_chain;

  localparam int          N      = 2;
  localparam logic [15:0] M_ID   = 16'h0A1C;
  localparam logic [31:0] SER    = 32'h0000_0000;
  localparam int          LAT    = 3;  // strobe edge to visible effect, in C7M

  logic C7M = 1'b0;
  logic RESET, CFGIN_n, AS_n, DS_n, RW_n;
  logic [7:0]   A_HIGH;
  logic [5:0]   A_LOW;
  logic [3:0]   D_IN, D_OUT, D_OE;
  logic [15:0]  BASE_ADDR;
  logic [1:0]   CONFIGURED_n, SHUTUP, ACTIVE_IDX;
  logic         CFGOUT_n;

  always #5 C7M = ~C7M;

  autoconfig_chain #(
    .N_BOARDS    (N),
    .MANUF_ID    (M_ID),
    .SERIAL      (SER),
    .ER_TYPE_VEC (16'hC1E6),
    .PRODUCT_VEC (16'h0201)
  ) dut (
    .C7M (C7M), .RESET (RESET), .CFGIN_n (CFGIN_n), .AS_n (AS_n), .DS_n (DS_n),
    .RW_n (RW_n), .A_HIGH (A_HIGH), .A_LOW (A_LOW), .D_IN (D_IN), .D_OUT (D_OUT),
    .D_OE (D_OE), .BASE_ADDR (BASE_ADDR), .CONFIGURED_n (CONFIGURED_n),
    .SHUTUP (SHUTUP), .CFGOUT_n (CFGOUT_n), .ACTIVE_IDX (ACTIVE_IDX)
  );

  int checks = 0;
  int failures = 0;

  // Model state.
  logic [7:0] m_base [N];
  logic [1:0] m_cfg_n, m_shut;
  logic [3:0] m_latch, exp_oe, exp_nib;
  logic       m_cfgin;
  int         m_idx;
  bit         chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_base[0] = 8'h00;
    m_base[1] = 8'h00;
    m_cfg_n   = 2'b11;
    m_shut    = 2'b00;
    m_latch   = 4'h0;
    m_idx     = 0;
    exp_oe    = 4'h0;
    exp_nib   = 4'h0;
  endtask

  // Config ROM content from the board's identity, addressed by byte offset.
  function automatic logic [3:0] rom_model(input int board, input logic [5:0] al);
    int         off;
    logic [7:0] er, pr;
    off = 2 * int'(al);
    er  = (board == 0) ? 8'hE6 : 8'hC1;
    pr  = (board == 0) ? 8'h01 : 8'h02;
    if (off == 0)                     return er[7:4];
    else if (off == 2)                return er[3:0];
    else if (off == 4)                return ~pr[7:4];
    else if (off == 6)                return ~pr[3:0];
    else if (off == 8 || off == 10)   return 4'hF;
    else if (off >= 16 && off <= 22)  return ~4'(M_ID >> (12 - 4 * ((off - 16) / 2)));
    else if (off >= 24 && off <= 38)  return ~4'(SER >> (28 - 4 * ((off - 24) / 2)));
    else if (off == 64 || off == 66)  return 4'h0;
    else                              return 4'hF;
  endfunction

  task automatic model_write(input logic [5:0] al, input logic [3:0] din);
    int off;
    off = 2 * int'(al);
    if (off == 'h4A) begin
      m_latch = din;
    end else if (off == 'h48) begin
      m_base[m_idx]  = {din, m_latch};
      m_cfg_n[m_idx] = 1'b0;
      m_idx++;
    end else if (off == 'h4C) begin
      m_shut[m_idx] = 1'b1;
      m_idx++;
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge C7M) begin
    if (chk_en) begin
      chk("D_OE", 32'(D_OE), 32'(exp_oe));
      if (exp_oe == 4'hF) chk("D_OUT", 32'(D_OUT), 32'(exp_nib));
      chk("BASE_ADDR", 32'(BASE_ADDR), 32'({m_base[1], m_base[0]}));
      chk("CONFIGURED_n", 32'(CONFIGURED_n), 32'(m_cfg_n));
      chk("SHUTUP", 32'(SHUTUP), 32'(m_shut));
      chk("CFGOUT_n", 32'(CFGOUT_n), 32'((m_idx == N) ? m_cfgin : 1'b1));
      chk("ACTIVE_IDX", 32'(ACTIVE_IDX), 32'((m_idx >= N) ? N - 1 : m_idx));
    end
  end

  task automatic set_cfgin(input logic v);
    @(negedge C7M);
    CFGIN_n = v;
    @(posedge C7M);
    m_cfgin = v;
  endtask

  // One bus cycle, AS_n and DS_n asserted together; DS_n held `hold` extra clocks.
  task automatic bus(input logic rw, input logic [7:0] ah, input logic [5:0] al,
                     input logic [3:0] din, input int hold,
                     output logic [3:0] nib, output logic [3:0] oe);
    bit answers;
    int board;
    @(negedge C7M);
    answers = !m_cfgin && (m_idx < N) && (ah == 8'hE8);
    board   = m_idx;
    A_HIGH = ah; A_LOW = al; RW_n = rw; D_IN = din;
    AS_n = 1'b0; DS_n = 1'b0;
    repeat (LAT) @(posedge C7M);
    if (answers && rw) begin
      exp_nib = rom_model(board, al);
      exp_oe  = 4'hF;
    end else if (answers) begin
      model_write(al, din);
    end
    repeat (hold) @(posedge C7M);
    @(negedge C7M);
    nib = D_OUT;
    oe  = D_OE;
    AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    repeat (LAT) @(posedge C7M);
    exp_oe = 4'h0;
    repeat (2) @(posedge C7M);
  endtask

  logic [3:0] nib, oe;
  logic [5:0] rd_off [13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                              6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h30};
  logic [3:0] rd_exp [13] = '{4'hE, 4'h6, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF,
                              4'h5, 4'hE, 4'h3, 4'hF, 4'h0, 4'hF};

  initial begin
    RESET = 1'b1; CFGIN_n = 1'b1; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    A_HIGH = 8'h00; A_LOW = 6'h00; D_IN = 4'h0;
    model_reset();
    m_cfgin = 1'b1;
    repeat (2) @(posedge C7M);
    chk_en = 1'b1;
    @(negedge C7M);
    chk("rst D_OUT", 32'(D_OUT), 32'h0);
    chk("rst D_OE", 32'(D_OE), 32'h0);
    chk("rst CONFIGURED_n", 32'(CONFIGURED_n), 32'h3);
    chk("rst CFGOUT_n", 32'(CFGOUT_n), 32'h1);
    RESET = 1'b0;

    // Chain not enabled: nothing answers, nothing changes.
    bus(1'b1, 8'hE8, 6'h00, 4'h0, 0, nib, oe);
    chk("cfgin_hi read oe", 32'(oe), 32'h0);
    bus(1'b0, 8'hE8, 6'h24, 4'h2, 0, nib, oe);
    chk("cfgin_hi write cfg", 32'(CONFIGURED_n), 32'h3);

    // Board 0 ROM.
    set_cfgin(1'b0);
    for (int i = 0; i < 13; i++) begin
      bus(1'b1, 8'hE8, rd_off[i], 4'h0, 0, nib, oe);
      chk($sformatf("b0 rd %0h", rd_off[i]), 32'(nib), 32'(rd_exp[i]));
      chk("b0 rd oe", 32'(oe), 32'hF);
    end
    bus(1'b1, 8'hE9, 6'h00, 4'h0, 0, nib, oe);
    chk("off-window oe", 32'(oe), 32'h0);

    // Board 0 gets $20; high write held long must commit once.
    bus(1'b0, 8'hE8, 6'h25, 4'h7, 0, nib, oe);
    bus(1'b0, 8'hE8, 6'h25, 4'h0, 0, nib, oe);
    bus(1'b0, 8'hE8, 6'h24, 4'h2, 20, nib, oe);
    chk("b0 base", 32'(BASE_ADDR), 32'h0020);
    chk("b0 cfg_n", 32'(CONFIGURED_n), 32'h2);
    chk("b0 active", 32'(ACTIVE_IDX), 32'h1);

    // Board 1 ROM.
    bus(1'b1, 8'hE8, 6'h02, 4'h0, 0, nib, oe);
    chk("b1 rd 02", 32'(nib), 32'hF);
    bus(1'b1, 8'hE8, 6'h00, 4'h0, 0, nib, oe);
    chk("b1 rd 00", 32'(nib), 32'hC);
    bus(1'b1, 8'hE8, 6'h03, 4'h0, 0, nib, oe);
    chk("b1 rd 03", 32'(nib), 32'hD);

    // Reset in the middle of a driven read.
    @(negedge C7M);
    A_HIGH = 8'hE8; A_LOW = 6'h01; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
    repeat (LAT) @(posedge C7M);
    exp_nib = rom_model(1, 6'h01);
    exp_oe  = 4'hF;
    @(negedge C7M);
    chk("pre-reset oe", 32'(D_OE), 32'hF);
    RESET = 1'b1;
    @(posedge C7M);
    model_reset();
    @(negedge C7M);
    chk("mid-reset oe", 32'(D_OE), 32'h0);
    chk("mid-reset idx", 32'(ACTIVE_IDX), 32'h0);
    chk("mid-reset cfg_n", 32'(CONFIGURED_n), 32'h3);
    chk("mid-reset cfgout", 32'(CFGOUT_n), 32'h1);
    AS_n = 1'b1; DS_n = 1'b1;
    repeat (3) @(posedge C7M);
    @(negedge C7M);
    RESET = 1'b0;

    // Reconfigure: board 0 at $A9, board 1 shut up, chain passes on.
    bus(1'b0, 8'hE8, 6'h25, 4'h9, 0, nib, oe);
    bus(1'b0, 8'hE8, 6'h24, 4'hA, 0, nib, oe);
    chk("b0 base 2", 32'(BASE_ADDR), 32'h00A9);
    bus(1'b0, 8'hE8, 6'h26, 4'h0, 0, nib, oe);
    chk("b1 shutup", 32'(SHUTUP), 32'h2);
    chk("done cfgout", 32'(CFGOUT_n), 32'h0);
    chk("done cfg_n", 32'(CONFIGURED_n), 32'h2);
    chk("done active", 32'(ACTIVE_IDX), 32'h1);
    bus(1'b1, 8'hE8, 6'h00, 4'h0, 0, nib, oe);
    chk("done read oe", 32'(oe), 32'h0);
    bus(1'b0, 8'hE8, 6'h24, 4'h5, 0, nib, oe);
    chk("done write base", 32'(BASE_ADDR), 32'h00A9);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
